// File: rtl/word_align_ctrl.sv
// Word aligner: slips ALIGNWD until DATAIN repeats PATTERN, then tracks lock.
// Define WORD_ALIGN_MANUAL_EN to add the MANUAL_SLIP input.
module word_align_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(8'hBC),
    parameter int               PULSE_W  = 2,
    parameter int               SETTLE   = 4,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               MAX_SLIP = 15
) (
    input  logic             CLKI,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] DATAIN,
`ifdef WORD_ALIGN_MANUAL_EN
    input  logic             MANUAL_SLIP,
`endif
    output logic             ALIGNWD,
    output logic             LOCKED,
    output logic             LOSS,
    output logic             ERR,
    output logic [7:0]       SLIP_CNT
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCK   = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam logic [7:0] PULSE_M1  = 8'(PULSE_W - 1);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
    localparam logic [7:0] LOCK_M1   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_M1   = 8'(LOSS_CNT - 1);
    localparam logic [7:0] MAX_C     = 8'(MAX_SLIP);

    state_t     state, state_d;
    logic [7:0] match_cnt, match_d;
    logic [7:0] miss_cnt, miss_d;
    logic [7:0] tmr, tmr_d;
    logic [7:0] slip_d;
    logic       loss_d;
    logic       match;

    assign match = (DATAIN == PATTERN);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef WORD_ALIGN_MANUAL_EN
    logic manual_q;
    logic manual_edge;

    assign manual_edge = MANUAL_SLIP & ~manual_q;

    always_ff @(posedge CLKI) begin
        if (RST) manual_q <= 1'b0;
        else     manual_q <= MANUAL_SLIP;
    end
`endif

    always_comb begin
        state_d = state;
        match_d = match_cnt;
        miss_d  = miss_cnt;
        tmr_d   = tmr;
        slip_d  = SLIP_CNT;
        loss_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_d = ST_SEARCH;
                slip_d  = 8'd0;
                match_d = 8'd0;
                miss_d  = 8'd0;
            end
            ST_SEARCH: begin
                if (match) begin
                    if (match_cnt == LOCK_M1) begin
                        state_d = ST_LOCK;
                        match_d = 8'd0;
                        miss_d  = 8'd0;
                    end else begin
                        match_d = sat_inc(match_cnt);
                    end
                end else begin
                    match_d = 8'd0;
                    if (SLIP_CNT == MAX_C) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                        slip_d  = sat_inc(SLIP_CNT);
                        tmr_d   = 8'd0;
                    end
                end
            end
            ST_SLIP: begin
                if (tmr == PULSE_M1) begin
                    state_d = ST_SETTLE;
                    tmr_d   = 8'd0;
                end else begin
                    tmr_d = sat_inc(tmr);
                end
            end
            ST_SETTLE: begin
                if (tmr == SETTLE_M1) begin
                    state_d = ST_SEARCH;
                    tmr_d   = 8'd0;
                    match_d = 8'd0;
                end else begin
                    tmr_d = sat_inc(tmr);
                end
            end
            ST_LOCK: begin
                if (match) begin
                    miss_d = 8'd0;
                end else if (miss_cnt == LOSS_M1) begin
                    // loss edge: restart search without using this word
                    state_d = ST_SEARCH;
                    loss_d  = 1'b1;
                    slip_d  = 8'd0;
                    match_d = 8'd0;
                    miss_d  = 8'd0;
                end else begin
                    miss_d = sat_inc(miss_cnt);
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef WORD_ALIGN_MANUAL_EN
        if (manual_edge && (state == ST_SEARCH || state == ST_LOCK)) begin
            state_d = ST_SLIP;
            slip_d  = sat_inc(SLIP_CNT);
            tmr_d   = 8'd0;
            match_d = 8'd0;
            miss_d  = 8'd0;
            loss_d  = 1'b0;
        end
`endif
        if (!ENABLE) begin
            state_d = ST_IDLE;
            slip_d  = SLIP_CNT;
            match_d = 8'd0;
            miss_d  = 8'd0;
            tmr_d   = 8'd0;
            loss_d  = 1'b0;
        end
    end

    always_ff @(posedge CLKI) begin
        if (RST) begin
            state     <= ST_IDLE;
            match_cnt <= 8'd0;
            miss_cnt  <= 8'd0;
            tmr       <= 8'd0;
            SLIP_CNT  <= 8'd0;
            ALIGNWD   <= 1'b0;
            LOCKED    <= 1'b0;
            LOSS      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_d;
            match_cnt <= match_d;
            miss_cnt  <= miss_d;
            tmr       <= tmr_d;
            SLIP_CNT  <= slip_d;
            ALIGNWD   <= (state_d == ST_SLIP);
            LOCKED    <= (state_d == ST_LOCK);
            LOSS      <= loss_d;
            ERR       <= (state_d == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_word_align_ctrl.sv
// Scoreboard bench for word_align_ctrl; the channel model rotates DATAIN
// left by one bit on every ALIGNWD rising edge.
module tb_word_align_ctrl;

  logic       clk;
  logic       RST;
  logic       ENABLE;
  logic [7:0] DATAIN;
  logic       ALIGNWD;
  logic       LOCKED;
  logic       LOSS;
  logic       ERR;
  logic [7:0] SLIP_CNT;

  word_align_ctrl dut (
    .CLKI     (clk),
    .RST      (RST),
    .ENABLE   (ENABLE),
    .DATAIN   (DATAIN),
    .ALIGNWD  (ALIGNWD),
    .LOCKED   (LOCKED),
    .LOSS     (LOSS),
    .ERR      (ERR),
    .SLIP_CNT (SLIP_CNT)
  );

  typedef struct {
    int          cyc;
    string       nm;
    logic [11:0] v;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic al_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic [11:0] got;
    forever begin
      @(negedge clk);
      got = {ALIGNWD, LOCKED, LOSS, ERR, SLIP_CNT};
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == cyc) begin
          n_tot++;
          if (got === sbq[i].v) n_pass++;
          else $display("FAIL %s cyc=%0d got=%h want=%h (A,L,LOSS,E,SC)",
                        sbq[i].nm, cyc, got, sbq[i].v);
          sbq.delete(i);
        end
      end
    end
  end

  task automatic expect_at(input int d, input string nm, input logic a,
                           input logic l, input logic lo, input logic e,
                           input logic [7:0] sc);
    exp_t x;
    x.cyc = cyc + d;
    x.nm  = nm;
    x.v   = {a, l, lo, e, sc};
    sbq.push_back(x);
  endtask

  task automatic chk(input string nm, input logic ok);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s cyc=%0d", nm, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ALIGNWD && !al_prev) DATAIN = {DATAIN[6:0], DATAIN[7]};
      al_prev = ALIGNWD;
    end
  endtask

  initial begin
    logic       a, l, e;
    logic [7:0] sc;
    int         k;
    RST = 1'b1;
    ENABLE = 1'b1;
    DATAIN = 8'hBC;
    @(negedge clk);
    expect_at(1, "rst_a", 0, 0, 0, 0, 8'd0);
    expect_at(2, "rst_b", 0, 0, 0, 0, 8'd0);
    step(2);
    RST = 1'b0;
    ENABLE = 1'b0;
    expect_at(1, "idle", 0, 0, 0, 0, 8'd0);
    step(1);

    ENABLE = 1'b1;
    for (int d = 1; d <= 4; d++) expect_at(d, "lock_wait", 0, 0, 0, 0, 8'd0);
    expect_at(5, "lock_on", 0, 1, 0, 0, 8'd0);
    expect_at(6, "lock_hold", 0, 1, 0, 0, 8'd0);
    step(6);
    if (LOCKED === 1'b1) n_pass++;
    else $display("FAIL direct_lock cyc=%0d", cyc);
    n_tot++;
    chk("direct_lock_sc", SLIP_CNT === 8'd0);

    ENABLE = 1'b0;
    expect_at(1, "dis", 0, 0, 0, 0, 8'd0);
    step(1);
    DATAIN = 8'h97;
    ENABLE = 1'b1;
    for (int d = 1; d <= 27; d++) begin
      a  = (d == 2) || (d == 3) || (d == 9) || (d == 10) ||
           (d == 16) || (d == 17);
      sc = (d < 2) ? 8'd0 : (d < 9) ? 8'd1 : (d < 16) ? 8'd2 : 8'd3;
      l  = (d >= 26);
      expect_at(d, "slip3", a, l, 0, 0, sc);
    end
    step(27);
    if (SLIP_CNT === 8'd3 && LOCKED === 1'b1) n_pass++;
    else $display("FAIL direct_slip3 cyc=%0d", cyc);
    n_tot++;

    DATAIN = 8'h00;
    expect_at(1, "miss1", 0, 1, 0, 0, 8'd3);
    step(1);
    expect_at(1, "miss2", 0, 1, 0, 0, 8'd3);
    step(1);
    DATAIN = 8'hBC;
    expect_at(1, "rematch", 0, 1, 0, 0, 8'd3);
    step(1);
    DATAIN = 8'h00;
    expect_at(1, "loss_m1", 0, 1, 0, 0, 8'd3);
    step(1);
    expect_at(1, "loss_m2", 0, 1, 0, 0, 8'd3);
    step(1);
    expect_at(1, "loss", 0, 0, 1, 0, 8'd0);
    step(1);
    expect_at(1, "reslip", 1, 0, 0, 0, 8'd1);
    step(1);
    if (ALIGNWD === 1'b1 && SLIP_CNT === 8'd1) n_pass++;
    else $display("FAIL direct_reslip cyc=%0d", cyc);
    n_tot++;

    ENABLE = 1'b0;
    expect_at(1, "abort", 0, 0, 0, 0, 8'd1);
    expect_at(2, "abort_idle", 0, 0, 0, 0, 8'd1);
    step(2);

    ENABLE = 1'b1;
    DATAIN = 8'h00;
    for (int d = 1; d <= 110; d++) begin
      a = (d >= 2) && (d <= 101) && (((d - 2) % 7) < 2);
      k = (d - 2) / 7 + 1;
      sc = (d < 2) ? 8'd0 : (k > 15) ? 8'd15 : 8'(k);
      e = (d >= 107);
      expect_at(d, "fail_run", a, 0, 0, e, sc);
    end
    step(110);
    if (ERR === 1'b1 && SLIP_CNT === 8'd15) n_pass++;
    else $display("FAIL direct_fail cyc=%0d", cyc);
    n_tot++;
    chk("direct_fail_al", ALIGNWD === 1'b0);
    ENABLE = 1'b0;
    expect_at(1, "err_clr", 0, 0, 0, 0, 8'd15);
    step(1);

    DATAIN = 8'hBC;
    ENABLE = 1'b1;
    expect_at(1, "restart", 0, 0, 0, 0, 8'd0);
    expect_at(5, "relock", 0, 1, 0, 0, 8'd0);
    step(5);
    RST = 1'b1;
    expect_at(1, "rst_lock", 0, 0, 0, 0, 8'd0);
    step(1);
    if (LOCKED === 1'b0) n_pass++;
    else $display("FAIL direct_rst cyc=%0d", cyc);
    n_tot++;
    RST = 1'b0;
    step(2);

    while (sbq.size() > 0) begin
      n_tot++;
      $display("FAIL %s never checked (due cyc=%0d, now %0d)",
               sbq[0].nm, sbq[0].cyc, cyc);
      sbq.delete(0);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
